oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite (OAM) DMA controller and CPU/DMA bus arbiter.
- Sits between the CPU core and mem_top on the CPU memory bus.
- A CPU write to the DMA register halts the CPU via cpu_rdy and takes the bus. It copies one 256-byte page to the OAM data port as alternating read/write cycles, then returns the bus to the CPU.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA; the write data is the source page.
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
XFER_LEN, 256, bytes per transfer; counter width is $clog2(XFER_LEN)+1.

Ports:
clk  input  1  system clock; all state on the rising edge
rst  input  1  asynchronous, active-high reset
cpu_addr  input  16  CPU address bus
cpu_dout  input  8  CPU write data
cpu_we  input  1  CPU write strobe
cpu_rdy  output  1  1 = CPU may advance; 0 = CPU halted
mem_addr  output  16  address to mem_top
mem_dout  output  8  write data to mem_top
mem_we  output  1  write strobe to mem_top
mem_din  input  8  read data from mem_top, valid in the same cycle as mem_addr
dma_active  output  1  1 while DMA owns the bus

Behaviour:
- Reset (async assert, sync release) puts the block in this state:
  - state=IDLE, cpu_rdy=1, dma_active=0.
  - page_r=0, cnt=0, data_r=0, parity_r=0.
  - Bus mux selects the CPU.
- parity_r toggles every clock while rst=0. The first cycle after reset release is even (parity_r=0).
- Bus mux is combinational:
  - dma_active=0: mem_addr=cpu_addr, mem_dout=cpu_dout, mem_we=cpu_we (zero latency).
  - dma_active=1: DMA drives all three; CPU inputs are ignored.
- Trigger: cpu_we=1 and cpu_addr==DMA_REG_ADDR in IDLE.
  - That write still passes through to memory.
  - page_r<=cpu_dout; next state HALT.
  - Any other address, including DMA_REG_ADDR+1, does not trigger.
- States:
  - IDLE: cpu_rdy=1, dma_active=0. Goes to HALT on trigger.
  - HALT (1 cycle): cpu_rdy=0, dma_active=1, mem_we=0, mem_addr=OAM_DATA_ADDR (dummy). Goes to ALIGN if parity_r==1 this cycle, else to READ.
  - ALIGN (1 cycle): same outputs as HALT. Goes to READ.
  - READ: mem_addr={page_r, cnt[7:0]}, mem_we=0. data_r<=mem_din at the clock edge. Goes to WRITE.
  - WRITE: mem_addr=OAM_DATA_ADDR, mem_dout=data_r, mem_we=1, cnt<=cnt+1. Goes to IDLE if cnt==XFER_LEN-1, else to READ.
- Leaving WRITE for IDLE: cnt<=0. cpu_rdy=1 and dma_active=0 in the first IDLE cycle.
- Latency:
  - Trigger write in cycle T → cpu_rdy=0 from T+1.
  - Halt length is 1 + {0|1} + 2*XFER_LEN: 513 cycles if cycle T+1 is even, 514 if odd.
- Source addressing: only the low byte increments. Page 0xFF reads 0xFF00..0xFFFF with no carry into the page.
- Trigger conditions while dma_active=1 are ignored; page_r and cnt are unchanged.
- Reset mid-transfer aborts immediately:
  - IDLE, cpu_rdy=1, bus returned to the CPU.
  - Partial OAM contents are left as written.
- No X propagation: when dma_active=0, mem_* equal the CPU inputs exactly.

Test Plan:
1. Basic transfer:
   - Stimulus: preload 0x0200+i with i^8'h5A; CPU writes 8'h02 to 0x4014.
   - Required: exactly 256 mem_we pulses at 0x2004 with data 0x5A,0x5B,…,(255^0x5A) in order; reads at 0x0200..0x02FF; cpu_rdy returns to 1.
2. Parity:
   - Stimulus: trigger so T+1 is even, then repeat so T+1 is odd.
   - Required: cpu_rdy low for exactly 513 cycles, then exactly 514 cycles; the ALIGN cycle shows mem_we=0.
3. Page wrap:
   - Stimulus: write 8'hFF to 0x4014.
   - Required: last read address is 0xFFFF; no access to 0x0000; 256 writes total.
4. Retrigger during DMA:
   - Stimulus: drive cpu_we=1, cpu_addr=0x4014, cpu_dout=0x03 during transfer byte 10.
   - Required: ignored; all 256 bytes still come from page 0x02.
5. Reset mid-DMA:
   - Stimulus: assert rst after the 100th write.
   - Required: cpu_rdy=1 and dma_active=0 asynchronously; mem_* follow CPU inputs. A subsequent trigger performs a full 256-byte transfer starting at offset 0.
6. Idle passthrough:
   - Stimulus: CPU writes 0x77 to 0x4015; CPU reads 0x8000.
   - Required: no trigger; mem_addr/mem_dout/mem_we equal CPU inputs in the same cycle; cpu_rdy stays 1.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller and CPU/DMA bus arbiter: a write to the DMA register halts
// the CPU and copies one page to the OAM data port as alternating read/write cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    input  logic [7:0]  mem_din,
    output logic        dma_active
);

    localparam int CNT_W = $clog2(XFER_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       page_r;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_r;
    logic             parity_r;
    logic             trigger;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; parity_r tracks even/odd cycles for read alignment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_r   <= 8'h00;
            cnt      <= '0;
            data_r   <= 8'h00;
            parity_r <= 1'b0;
        end else begin
            parity_r <= ~parity_r;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        page_r <= cpu_dout;
                    end
                end
                READ: begin
                    data_r <= mem_din;
                end
                WRITE: begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = HALT;
            HALT:    state_next = parity_r ? ALIGN : READ;
            ALIGN:   state_next = READ;
            READ:    state_next = WRITE;
            WRITE:   state_next = (cnt == LAST) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the CPU owns the bus combinationally whenever DMA is not running
    always_comb begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        mem_addr   = cpu_addr;
        mem_dout   = cpu_dout;
        mem_we     = cpu_we;
        case (state_reg)
            HALT, ALIGN: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                mem_addr   = OAM_DATA_ADDR;
                mem_dout   = data_r;
                mem_we     = 1'b0;
            end
            READ: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                mem_addr   = {page_r, cnt[7:0]};
                mem_dout   = data_r;
                mem_we     = 1'b0;
            end
            WRITE: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                mem_addr   = OAM_DATA_ADDR;
                mem_dout   = data_r;
                mem_we     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus pushes expected read addresses, write data
// and halt lengths; a negedge monitor pops and compares as the DMA bus activity appears.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        dma_active;

    typedef struct {
        logic [15:0] raddr;
        logic [7:0]  wdata;
    } xfer_t;

    typedef struct {
        int len;
        int dummies;
        logic [7:0] page;
    } halt_t;

    xfer_t xfer_q[$];
    halt_t halt_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int low_cnt = 0;
    int dummy_cnt = 0;
    int xfer_wr = 0;

    logic [7:0] mem [0:65535];

    oam_dma_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Source memory contents: page 0x02 holds i^0x5A, every other byte a^hi^0x3C
    function automatic logic [7:0] src(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign mem_din = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_dout;
    end

    // Cycle index since reset release; even cycles have index bit 0 clear
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            xfer_q.delete();
            halt_q.delete();
            low_cnt   = 0;
            dummy_cnt = 0;
            xfer_wr   = 0;
        end else begin
            if (dma_active) begin
                if (mem_we) begin
                    chk("wr_addr", 32'(mem_addr), 32'h2004);
                    if (xfer_q.size() == 0) begin
                        fail_now("wr_extra");
                    end else begin
                        xfer_t e;
                        e = xfer_q.pop_front();
                        chk("wr_data", 32'(mem_dout), 32'(e.wdata));
                        xfer_wr++;
                    end
                end else if (mem_addr == 16'h2004) begin
                    dummy_cnt++;
                end else if (xfer_q.size() == 0) begin
                    fail_now("rd_extra");
                end else begin
                    chk("rd_addr", 32'(mem_addr), 32'(xfer_q[0].raddr));
                end
            end
            if (!cpu_rdy) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                if (halt_q.size() == 0) begin
                    fail_now("halt_extra");
                end else begin
                    halt_t h;
                    h = halt_q.pop_front();
                    chk("halt_len", 32'(low_cnt), 32'(h.len));
                    chk("dummy_cycles", 32'(dummy_cnt), 32'(h.dummies));
                    chk("write_count", 32'(xfer_wr), 32'd256);
                    chk("end_dma_active", 32'(dma_active), 32'd0);
                    $display("xfer page=%02h halt=%0d dummies=%0d writes=%0d",
                             h.page, low_cnt, dummy_cnt, xfer_wr);
                end
                low_cnt   = 0;
                dummy_cnt = 0;
                xfer_wr   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger a DMA so that cycle T+1 has the requested parity
    task automatic start_dma(input logic [7:0] page, input bit odd_next);
        while (cyc[0] == odd_next) tick();
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, 8'(i)};
            xfer_q.push_back('{raddr: a, wdata: src(a)});
        end
        halt_q.push_back('{len: odd_next ? 514 : 513, dummies: odd_next ? 2 : 1, page: page});
        cpu_addr = 16'h4014;
        cpu_dout = page;
        cpu_we   = 1'b1;
        #1;
        chk("trig_pass_we", 32'(mem_we), 32'd1);
        chk("trig_pass_addr", 32'(mem_addr), 32'h4014);
        tick();
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        chk("halt_rdy", 32'(cpu_rdy), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (halt_q.size() != 0 && n < 1500) begin
            tick();
            n++;
        end
        if (halt_q.size() != 0) fail_now("dma_timeout");
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (xfer_wr < target && n < 1500) begin
            tick();
            n++;
        end
        if (xfer_wr < target) fail_now("write_timeout");
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = src(16'(a));

        // Reset state and passthrough while in reset
        cpu_addr = 16'h0123;
        cpu_dout = 8'h45;
        tick();
        tick();
        chk("rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0123);
        chk("rst_dout", 32'(mem_dout), 32'h45);
        rst = 1'b0;
        tick();

        // Idle passthrough, including the neighbouring non-trigger address
        cpu_addr = 16'h4015;
        cpu_dout = 8'h77;
        cpu_we   = 1'b1;
        #1;
        chk("pass_addr", 32'(mem_addr), 32'h4015);
        chk("pass_dout", 32'(mem_dout), 32'h77);
        chk("pass_we", 32'(mem_we), 32'd1);
        tick();
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        #1;
        chk("pass_rdy", 32'(cpu_rdy), 32'd1);
        chk("pass_noact", 32'(dma_active), 32'd0);
        chk("pass_rd_addr", 32'(mem_addr), 32'h8000);
        chk("pass_rd_we", 32'(mem_we), 32'd0);
        chk("pass_rd_din", 32'(mem_din), 32'hBC);
        tick();
        chk("pass_rdy2", 32'(cpu_rdy), 32'd1);

        // Basic transfer with even T+1, then odd T+1
        start_dma(8'h02, 1'b0);
        wait_done();
        start_dma(8'h02, 1'b1);
        wait_done();

        // Page 0xFF: low byte wraps without carry
        start_dma(8'hFF, 1'b0);
        wait_done();

        // Retrigger during byte 10 is ignored
        start_dma(8'h02, 1'b1);
        wait_writes(10);
        cpu_addr = 16'h4014;
        cpu_dout = 8'h03;
        cpu_we   = 1'b1;
        tick();
        tick();
        tick();
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        wait_done();

        // Reset after the 100th write aborts immediately
        start_dma(8'h02, 1'b0);
        wait_writes(100);
        cpu_addr = 16'h5555;
        cpu_dout = 8'h99;
        cpu_we   = 1'b0;
        rst      = 1'b1;
        #1;
        chk("abort_rdy", 32'(cpu_rdy), 32'd1);
        chk("abort_active", 32'(dma_active), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'h5555);
        chk("abort_dout", 32'(mem_dout), 32'h99);
        chk("abort_we", 32'(mem_we), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        start_dma(8'h02, 1'b0);
        wait_done();

        tick();
        chk("final_rdy", 32'(cpu_rdy), 32'd1);
        chk("final_q_empty", 32'(xfer_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
